quant_feature_sequencer: RTL and testbench

Sequences one frame of NUM_FEATURES float32 feature values through the external 10-level quantizer.
- Reads each feature from the feature buffer and presents it to the quantizer with its enable for one cycle.
- Emits (feature index, level) pairs to the level-hypervector LUT stage over a valid/ready handshake.
- Sits between the feature SRAM and the LUT/encoder in the sparse HDC encode path.

---
 rtl/hdc_quant_pkg.sv | 25 ++
 rtl/quant_feature_sequencer.sv | 137 +++++++++++++
 tb/tb_quant_feature_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdc_quant_pkg.sv
// Shared definitions for the HDC quantization front end: sequencer state
// encoding, quantizer level range and data widths.
package hdc_quant_pkg;

  localparam int FLOAT_W    = 32;
  localparam int DEF_LVL_W  = 4;
  localparam int NUM_LEVELS = 10;
  localparam int MAX_LEVEL  = NUM_LEVELS - 1;

  // Sequencer state encoding. Kept as plain constants so that legacy
  // blocks comparing raw state codes still work.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_QUANT  = 3'd2;
  localparam state_t ST_EMIT   = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

  // A level is invalid when it lies above the top quantizer level.
  function automatic logic lvl_is_bad(input logic [31:0] lvl);
    return (lvl > 32'(MAX_LEVEL));
  endfunction

endpackage

// File: rtl/quant_feature_sequencer.sv
// Walks one frame of float32 features through the external quantizer:
// FETCH reads the feature SRAM, QUANT hands the value to the quantizer,
// EMIT offers (index, level) downstream over valid/ready, FINISH pulses done.
module quant_feature_sequencer
  import hdc_quant_pkg::*;
#(
  parameter int NUM_FEATURES = 617,
  parameter int IDX_W        = 10,
  parameter int LVL_W        = DEF_LVL_W
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               feat_rd_en,
  output logic [IDX_W-1:0]   feat_rd_addr,
  input  logic [FLOAT_W-1:0] feat_rd_data,
  output logic [FLOAT_W-1:0] q_value,
  output logic               q_en,
  input  logic [LVL_W-1:0]   q_level,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [LVL_W-1:0]   out_level,
  output logic               lvl_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [LVL_W-1:0] level_hold;
  logic             start_accept;

  assign start_accept = (state == ST_IDLE) && start && !abort;

  // Next-state and index logic; abort overrides every non-idle transition.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if ((state != ST_IDLE) && abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_accept) begin
            state_nxt = ST_FETCH;
            idx_nxt   = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_FETCH:  state_nxt = ST_QUANT;
        ST_QUANT:  state_nxt = ST_EMIT;
        ST_EMIT: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state_nxt = ST_FINISH;
            end else begin
              state_nxt = ST_FETCH;
              idx_nxt   = idx + IDX_ONE;
            end
          end else begin
            state_nxt = ST_EMIT;
          end
        end
        ST_FINISH: state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and frame index registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Output index is loaded only when an EMIT is actually entered, so an
  // abort during QUANT leaves the previously emitted index visible.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_idx <= '0;
    end else if ((state == ST_QUANT) && (state_nxt == ST_EMIT)) begin
      out_idx <= idx;
    end else begin
      out_idx <= out_idx;
    end
  end

  // Remember the last emitted level so it is still presented after EMIT.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      level_hold <= '0;
    end else if (state == ST_EMIT) begin
      level_hold <= q_level;
    end else begin
      level_hold <= level_hold;
    end
  end

  // Sticky out-of-range level flag, cleared by an accepted start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lvl_err <= 1'b0;
    end else if (start_accept) begin
      lvl_err <= 1'b0;
    end else if ((state == ST_EMIT) && lvl_is_bad(32'(q_level))) begin
      lvl_err <= 1'b1;
    end else begin
      lvl_err <= lvl_err;
    end
  end

  // Strobes decode straight from the state register. q_level is already a
  // register inside the quantizer, so during EMIT it is forwarded as-is and
  // the held copy takes over afterwards.
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_FINISH);
  assign feat_rd_en   = (state == ST_FETCH);
  assign feat_rd_addr = (state == ST_FETCH) ? idx : '0;
  assign q_value      = feat_rd_data;
  assign q_en         = (state == ST_QUANT);
  assign out_valid    = (state == ST_EMIT);
  assign out_level    = (state == ST_EMIT) ? q_level : level_hold;

endmodule

// File: tb/tb_quant_feature_sequencer.sv
// Directed bench for quant_feature_sequencer: a 4-feature instance with a
// stub SRAM and stub quantizer, plus a single-feature instance.
module tb_quant_feature_sequencer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start, abort, out_ready;
  logic        busy, done, feat_rd_en, q_en, out_valid, lvl_err;
  logic [9:0]  feat_rd_addr, out_idx;
  logic [31:0] feat_rd_data, q_value;
  logic [3:0]  q_level, out_level;

  logic        start1;
  logic        busy1, done1, feat_rd_en1, q_en1, out_valid1, lvl_err1;
  logic [0:0]  feat_rd_addr1, out_idx1;
  logic [31:0] feat_rd_data1, q_value1;
  logic [3:0]  q_level1, out_level1;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int em_idx[$];
  int em_lvl[$];
  int em_cyc[$];
  int done_cyc[$];

  always #5 clk = ~clk;

  quant_feature_sequencer #(.NUM_FEATURES(4), .IDX_W(10), .LVL_W(4)) dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .busy(busy), .done(done), .feat_rd_en(feat_rd_en),
    .feat_rd_addr(feat_rd_addr), .feat_rd_data(feat_rd_data),
    .q_value(q_value), .q_en(q_en), .q_level(q_level),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_level(out_level), .lvl_err(lvl_err)
  );

  quant_feature_sequencer #(.NUM_FEATURES(1), .IDX_W(1), .LVL_W(4)) dut1 (
    .clk(clk), .nrst(nrst), .start(start1), .abort(1'b0),
    .busy(busy1), .done(done1), .feat_rd_en(feat_rd_en1),
    .feat_rd_addr(feat_rd_addr1), .feat_rd_data(feat_rd_data1),
    .q_value(q_value1), .q_en(q_en1), .q_level(q_level1),
    .out_valid(out_valid1), .out_ready(1'b1), .out_idx(out_idx1),
    .out_level(out_level1), .lvl_err(lvl_err1)
  );

  // Stub quantizer: maps the known test values to their levels.
  function automatic logic [3:0] quant_stub(input logic [31:0] v);
    case (v)
      32'h3F733333: return 4'd0;   //  0.95
      32'h3F000000: return 4'd2;   //  0.5
      32'hBDCCCCCD: return 4'd5;   // -0.1
      32'hBF733333: return 4'd9;   // -0.95
      32'h41400000: return 4'd12;  //  12.0, out of range
      default:      return 4'd15;
    endcase
  endfunction

  // Stub SRAM with one-cycle read latency, and registered quantizers.
  always @(posedge clk) begin
    if (feat_rd_en)  feat_rd_data  <= mem[feat_rd_addr];
    if (feat_rd_en1) feat_rd_data1 <= mem[{9'd0, feat_rd_addr1} + 10'd2];
    if (q_en)        q_level       <= quant_stub(q_value);
    if (q_en1)       q_level1      <= quant_stub(q_value1);
  end

  // Free-running cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Log accepted transfers, done pulses and SRAM reads mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      em_idx.push_back(int'(out_idx));
      em_lvl.push_back(int'(out_level));
      em_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (feat_rd_en) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wait for the frame to leave busy, with a cycle budget.
  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
    check({tag, "_timeout"}, int'(busy), 0);
  endtask

  // Four emissions starting base in the log, 3 cycles apart from first_cyc.
  task automatic check_frame(input string tag, input int base, input int t0,
                             input int first_cyc, input int lvl1);
    int exp_lvl [4];
    exp_lvl = '{0, lvl1, 5, 9};
    check({tag, "_count"}, em_idx.size() - base, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_idx%0d", tag, k), em_idx[base + k], k);
      check($sformatf("%s_lvl%0d", tag, k), em_lvl[base + k], exp_lvl[k]);
      check($sformatf("%s_cyc%0d", tag, k), em_cyc[base + k] - t0, first_cyc + 3 * k);
    end
  endtask

  int b, bd, br, t0;

  initial begin
    nrst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; start1 = 1'b0;
    mem[0] = 32'h3F733333;
    mem[1] = 32'h3F000000;
    mem[2] = 32'hBDCCCCCD;
    mem[3] = 32'hBF733333;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(feat_rd_en), 0);
    check("rst_rd_addr", int'(feat_rd_addr), 0);
    check("rst_q_en", int'(q_en), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_level", int'(out_level), 0);
    check("rst_lvl_err", int'(lvl_err), 0);
    nrst = 1'b1;
    tick();

    // Scenario 1: plain frame with out_ready held high.
    b = em_idx.size(); bd = done_cyc.size(); br = rd_cnt;
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    check("s1_fetch_addr", int'(feat_rd_addr), 0);
    wait_idle("s1", 40);
    check("s1_idle_cyc", cyc - t0, 14);
    check_frame("s1", b, t0, 3, 2);
    check("s1_done_count", done_cyc.size() - bd, 1);
    check("s1_done_cyc", done_cyc[bd] - t0, 13);
    check("s1_reads", rd_cnt - br, 4);
    check("s1_lvl_err", int'(lvl_err), 0);

    // Scenario 2: 5-cycle stall on the first EMIT.
    b = em_idx.size(); bd = done_cyc.size(); br = rd_cnt;
    out_ready = 1'b0;
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    tick(); tick();
    check("s2_valid_c3", int'(out_valid), 1);
    check("s2_idx_c3", int'(out_idx), 0);
    check("s2_lvl_c3", int'(out_level), 0);
    repeat (4) tick();
    check("s2_valid_c7", int'(out_valid), 1);
    check("s2_idx_c7", int'(out_idx), 0);
    check("s2_lvl_c7", int'(out_level), 0);
    check("s2_reads_stall", rd_cnt - br, 1);
    tick();
    out_ready = 1'b1;
    wait_idle("s2", 40);
    check_frame("s2", b, t0, 8, 2);
    check("s2_done_cyc", done_cyc[bd] - t0, 18);
    check("s2_reads", rd_cnt - br, 4);

    // Scenario 3: abort in the QUANT cycle of idx 2, then restart.
    b = em_idx.size(); bd = done_cyc.size();
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    repeat (7) tick();
    check("s3_in_quant", int'(q_en), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("s3_busy", int'(busy), 0);
    check("s3_valid", int'(out_valid), 0);
    check("s3_out_idx_kept", int'(out_idx), 1);
    repeat (5) tick();
    check("s3_emits", em_idx.size() - b, 2);
    check("s3_no_done", done_cyc.size() - bd, 0);
    b = em_idx.size();
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    wait_idle("s3r", 40);
    check_frame("s3r", b, t0, 3, 2);

    // Scenario 4a: start held high across a whole frame.
    b = em_idx.size(); bd = done_cyc.size();
    start = 1'b1; t0 = cyc;
    repeat (13) tick();
    check("s4_done_c13", int'(done), 1);
    tick();
    check("s4_idle_c14", int'(busy), 0);
    tick();
    check("s4_refetch_c15", int'(feat_rd_en), 1);
    check("s4_refetch_addr", int'(feat_rd_addr), 0);
    start = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    check("s4_abort_busy", int'(busy), 0);
    check_frame("s4", b, t0, 3, 2);
    check("s4_done_count", done_cyc.size() - bd, 1);

    // Scenario 4b: start and abort together in IDLE.
    start = 1'b1; abort = 1'b1; tick();
    check("s4b_busy", int'(busy), 0);
    start = 1'b0; abort = 1'b0; tick();
    check("s4b_rd_en", int'(feat_rd_en), 0);

    // Scenario 6a: out-of-range level on idx 1.
    mem[1] = 32'h41400000;
    b = em_idx.size();
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    wait_idle("s6", 40);
    check_frame("s6", b, t0, 3, 12);
    check("s6_lvl_err", int'(lvl_err), 1);
    repeat (4) tick();
    check("s6_lvl_err_sticky", int'(lvl_err), 1);

    // Scenario 5: asynchronous reset during a stalled EMIT of idx 1.
    bd = done_cyc.size();
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    check("s5_lvl_err_cleared", int'(lvl_err), 0);
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (3) tick();
    check("s5_valid_pre", int'(out_valid), 1);
    check("s5_idx_pre", int'(out_idx), 1);
    check("s5_lvl_pre", int'(out_level), 12);
    check("s5_lvl_err_pre", int'(lvl_err), 1);
    #2 nrst = 1'b0;
    #1;
    check("s5_valid", int'(out_valid), 0);
    check("s5_busy", int'(busy), 0);
    check("s5_out_idx", int'(out_idx), 0);
    check("s5_out_level", int'(out_level), 0);
    check("s5_lvl_err", int'(lvl_err), 0);
    check("s5_rd_en", int'(feat_rd_en), 0);
    check("s5_q_en", int'(q_en), 0);
    check("s5_done", int'(done), 0);
    @(negedge clk);
    nrst = 1'b1; out_ready = 1'b1;
    mem[1] = 32'h3F000000;
    tick();
    check("s5_post_busy", int'(busy), 0);
    check("s5_post_lvl_err", int'(lvl_err), 0);
    check("s5_no_done", done_cyc.size() - bd, 0);

    // Scenario 6b: single-feature frame.
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick(); tick();
    check("s6b_valid", int'(out_valid1), 1);
    check("s6b_idx", int'(out_idx1), 0);
    check("s6b_lvl", int'(out_level1), 5);
    tick();
    check("s6b_done", int'(done1), 1);
    check("s6b_valid_off", int'(out_valid1), 0);
    tick();
    check("s6b_busy", int'(busy1), 0);
    check("s6b_done_off", int'(done1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
